// File: rtl/cmp_scan_seq_pkg.sv
// rtl/cmp_scan_seq_pkg.sv - shared widths, defaults and FSM encoding for the compare-scan sequencer
package cmp_scan_seq_pkg;

    localparam int EXTENDED_SINGLE = 64;
    localparam int NUM_CH_DEF      = 8;
    localparam int ADDR_W_DEF      = 3;

    typedef enum logic [1:0] {
        CMP_SCAN_IDLE  = 2'd0,
        CMP_SCAN_ISSUE = 2'd1,
        CMP_SCAN_DRAIN = 2'd2,
        CMP_SCAN_DONE  = 2'd3
    } cmp_scan_state_e;

endpackage

// File: rtl/cmp_scan_seq_if.sv
// rtl/cmp_scan_seq_if.sv - operand RAM read port and comparator issue/return bundle
interface cmp_scan_seq_if
    import cmp_scan_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = EXTENDED_SINGLE
) ();

    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              cmp_sta;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic              cmp_gt;
    logic              cmp_lt;
    logic              cmp_done;

    modport master (
        output rd_addr, cmp_sta, cmp_a, cmp_b,
        input  rd_data_a, rd_data_b, cmp_gt, cmp_lt, cmp_done
    );

    modport slave (
        input  rd_addr, cmp_sta, cmp_a, cmp_b,
        output rd_data_a, rd_data_b, cmp_gt, cmp_lt, cmp_done
    );

endinterface

// File: rtl/cmp_scan_collect.sv
// rtl/cmp_scan_collect.sv - in-order result capture, shadow masks and publish; CMP_SCAN_STICKY_EN adds sticky gt/lt
module cmp_scan_collect
    import cmp_scan_seq_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  cmp_scan_state_e   state_i,
    input  logic              clr_i,
    input  logic              cmp_done_i,
    input  logic              cmp_gt_i,
    input  logic              cmp_lt_i,
`ifdef CMP_SCAN_STICKY_EN
    input  logic              sticky_clr_i,
`endif
    output logic              last_o,
    output logic [NUM_CH-1:0] gt_mask_o,
    output logic [NUM_CH-1:0] lt_mask_o,
    output logic [NUM_CH-1:0] eq_mask_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CH - 1);

    logic [ADDR_W-1:0] ret_cnt_q, ret_cnt_d;
    logic [NUM_CH-1:0] sh_gt_q, sh_gt_d, sh_lt_q, sh_lt_d, sh_eq_q, sh_eq_d;
    logic [NUM_CH-1:0] gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
    logic              take;
    logic              publish;

    // Results only count while a scan is live, so stale returns after reset are dropped.
    assign take    = cmp_done_i && (state_i == CMP_SCAN_ISSUE || state_i == CMP_SCAN_DRAIN);
    assign last_o  = take && (ret_cnt_q == LAST_IDX);
    assign publish = last_o && (state_i == CMP_SCAN_DRAIN);

    always_comb begin
        ret_cnt_d = ret_cnt_q;
        sh_gt_d   = sh_gt_q;
        sh_lt_d   = sh_lt_q;
        sh_eq_d   = sh_eq_q;
        if (clr_i) begin
            ret_cnt_d = '0;
            sh_gt_d   = '0;
            sh_lt_d   = '0;
            sh_eq_d   = '0;
        end else if (take) begin
            sh_gt_d[ret_cnt_q] = cmp_gt_i;
            sh_lt_d[ret_cnt_q] = cmp_lt_i;
            sh_eq_d[ret_cnt_q] = ~cmp_gt_i & ~cmp_lt_i;
            ret_cnt_d          = ret_cnt_q + ADDR_W'(1);
        end
    end

    // Publishing from the _d shadows folds the final result in on the same edge.
    always_comb begin
        gt_d = gt_q;
        lt_d = lt_q;
        eq_d = eq_q;
        if (publish) begin
            eq_d = sh_eq_d;
        end
`ifdef CMP_SCAN_STICKY_EN
        if (sticky_clr_i) begin
            gt_d = '0;
            lt_d = '0;
        end else if (publish) begin
            gt_d = gt_q | sh_gt_d;
            lt_d = lt_q | sh_lt_d;
        end
`else
        if (publish) begin
            gt_d = sh_gt_d;
            lt_d = sh_lt_d;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ret_cnt_q <= '0;
            sh_gt_q   <= '0;
            sh_lt_q   <= '0;
            sh_eq_q   <= '0;
            gt_q      <= '0;
            lt_q      <= '0;
            eq_q      <= '0;
        end else begin
            ret_cnt_q <= ret_cnt_d;
            sh_gt_q   <= sh_gt_d;
            sh_lt_q   <= sh_lt_d;
            sh_eq_q   <= sh_eq_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            eq_q      <= eq_d;
        end
    end

    assign gt_mask_o = gt_q;
    assign lt_mask_o = lt_q;
    assign eq_mask_o = eq_q;

endmodule

// File: rtl/cmp_scan_seq.sv
// rtl/cmp_scan_seq.sv - scan FSM and compare-issue pipeline; CMP_SCAN_STICKY_EN adds sticky_clr_i
module cmp_scan_seq
    import cmp_scan_seq_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = EXTENDED_SINGLE
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
`ifdef CMP_SCAN_STICKY_EN
    input  logic              sticky_clr_i,
`endif
    cmp_scan_seq_if.master    bus,
    output logic [NUM_CH-1:0] gt_mask_o,
    output logic [NUM_CH-1:0] lt_mask_o,
    output logic [NUM_CH-1:0] eq_mask_o,
    output logic              busy_o,
    output logic              done_sig_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CH - 1);

    cmp_scan_state_e   state_q, state_d;
    logic [ADDR_W-1:0] issue_cnt_q, issue_cnt_d;
    logic              clr;
    logic              last_ret;
    logic              rd_vld_q;
    logic              sta_q;
    logic [DATA_W-1:0] cmp_a_q, cmp_b_q;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        clr         = 1'b0;
        unique case (state_q)
            CMP_SCAN_IDLE: begin
                if (start_i) begin
                    state_d     = CMP_SCAN_ISSUE;
                    issue_cnt_d = '0;
                    clr         = 1'b1;
                end
            end
            CMP_SCAN_ISSUE: begin
                if (issue_cnt_q == LAST_IDX) begin
                    state_d     = CMP_SCAN_DRAIN;
                    issue_cnt_d = '0;
                end else begin
                    issue_cnt_d = issue_cnt_q + ADDR_W'(1);
                end
            end
            CMP_SCAN_DRAIN: begin
                if (last_ret) begin
                    state_d = CMP_SCAN_DONE;
                end
            end
            CMP_SCAN_DONE: begin
                state_d = CMP_SCAN_IDLE;
            end
            default: state_d = CMP_SCAN_IDLE;
        endcase
    end

    // RAM data lands one cycle after the address; cmp_sta follows one register later.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= CMP_SCAN_IDLE;
            issue_cnt_q <= '0;
            rd_vld_q    <= 1'b0;
            sta_q       <= 1'b0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rd_vld_q    <= (state_q == CMP_SCAN_ISSUE);
            sta_q       <= rd_vld_q;
            if (rd_vld_q) begin
                cmp_a_q <= bus.rd_data_a;
                cmp_b_q <= bus.rd_data_b;
            end
        end
    end

    assign bus.rd_addr = issue_cnt_q;
    assign bus.cmp_sta = sta_q;
    assign bus.cmp_a   = cmp_a_q;
    assign bus.cmp_b   = cmp_b_q;

    assign busy_o     = (state_q == CMP_SCAN_ISSUE) || (state_q == CMP_SCAN_DRAIN);
    assign done_sig_o = (state_q == CMP_SCAN_DONE);

    cmp_scan_collect #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W)
    ) u_collect (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .state_i      (state_q),
        .clr_i        (clr),
        .cmp_done_i   (bus.cmp_done),
        .cmp_gt_i     (bus.cmp_gt),
        .cmp_lt_i     (bus.cmp_lt),
`ifdef CMP_SCAN_STICKY_EN
        .sticky_clr_i (sticky_clr_i),
`endif
        .last_o       (last_ret),
        .gt_mask_o    (gt_mask_o),
        .lt_mask_o    (lt_mask_o),
        .eq_mask_o    (eq_mask_o)
    );

endmodule

// File: tb/tb_cmp_scan_seq.sv
// tb/tb_cmp_scan_seq.sv - randomized scans against a mask/timing reference model; CMP_SCAN_STICKY_EN adds sticky checks
module tb_cmp_scan_seq;

    localparam int NCH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sticky_clr = 1'b0;
    logic [7:0] gt_mask, lt_mask, eq_mask;
    logic       busy, done_sig;

    int n_tests = 0;
    int n_fail  = 0;

    cmp_scan_seq_if #(.ADDR_W(3), .DATA_W(64)) bus ();

    cmp_scan_seq #(.NUM_CH(NCH), .ADDR_W(3), .DATA_W(64)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
`ifdef CMP_SCAN_STICKY_EN
        .sticky_clr_i (sticky_clr),
`endif
        .bus          (bus),
        .gt_mask_o    (gt_mask),
        .lt_mask_o    (lt_mask),
        .eq_mask_o    (eq_mask),
        .busy_o       (busy),
        .done_sig_o   (done_sig)
    );

    always #5 clk = ~clk;

    // Operand RAM: registered read, data valid one cycle after the address.
    logic [63:0] mem_a [NCH];
    logic [63:0] mem_b [NCH];
    always @(posedge clk) begin
        bus.rd_data_a <= mem_a[bus.rd_addr];
        bus.rd_data_b <= mem_b[bus.rd_addr];
    end

    // Comparator with programmable fixed latency; deliberately not reset.
    int          lat = 1;
    logic [15:0] p_v = '0, p_g = '0, p_l = '0;
    always @(posedge clk) begin
        p_v <= {p_v[14:0], bus.cmp_sta};
        p_g <= {p_g[14:0], bus.cmp_a > bus.cmp_b};
        p_l <= {p_l[14:0], bus.cmp_a < bus.cmp_b};
    end
    assign bus.cmp_done = p_v[lat-1];
    assign bus.cmp_gt   = p_g[lat-1];
    assign bus.cmp_lt   = p_l[lat-1];

    int  sta_cnt = 0, sta_run = 0, done_cnt = 0;
    time sta_last_t = 0;
    always @(negedge clk) begin
        if (bus.cmp_sta) begin
            sta_run    = (sta_cnt != 0 && $time - sta_last_t == 10) ? sta_run + 1 : 1;
            sta_last_t = $time;
            sta_cnt++;
        end
        if (done_sig) done_cnt++;
    end

    logic [7:0] exp_gt = '0, exp_lt = '0, exp_eq = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_scan();
        logic [7:0] g, l, e;
        for (int i = 0; i < NCH; i++) begin
            g[i] = mem_a[i] > mem_b[i];
            l[i] = mem_a[i] < mem_b[i];
            e[i] = mem_a[i] == mem_b[i];
        end
`ifdef CMP_SCAN_STICKY_EN
        exp_gt = exp_gt | g;
        exp_lt = exp_lt | l;
`else
        exp_gt = g;
        exp_lt = l;
`endif
        exp_eq = e;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NCH; i++) begin
            mem_a[i] = {$urandom, $urandom};
            case ($urandom_range(2))
                0:       mem_b[i] = mem_a[i];
                1:       mem_b[i] = {$urandom, $urandom};
                default: mem_b[i] = mem_a[i] + 64'($urandom_range(1, 3));
            endcase
        end
    endtask

    task automatic run_scan(input int l, input bit extra, input string tag);
        time t0, td;
        bit  seen;
        int  sta0, done0, guard;
        lat = l;
        model_scan();
        @(negedge clk);
        sta0  = sta_cnt;
        done0 = done_cnt;
        start = 1'b1;
        t0    = $time;
        @(negedge clk);
        start = 1'b0;
        if (extra) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        seen  = 1'b0;
        td    = 0;
        guard = 0;
        while (!seen && guard < 200) begin
            if (done_sig) begin
                seen = 1'b1;
                td   = $time;
            end else begin
                @(negedge clk);
                guard++;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (extra) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (20) @(negedge clk);
        check({tag, "_gt"}, 64'(gt_mask), 64'(exp_gt));
        check({tag, "_lt"}, 64'(lt_mask), 64'(exp_lt));
        check({tag, "_eq"}, 64'(eq_mask), 64'(exp_eq));
        check({tag, "_sta_cnt"}, 64'(sta_cnt - sta0), 64'(NCH));
        check({tag, "_sta_consec"}, 64'(sta_run), 64'(NCH));
        check({tag, "_done_cnt"}, 64'(done_cnt - done0), 64'd1);
        check({tag, "_latency"}, 64'((td - t0) / 10), 64'(NCH + l + 3));
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic basic_data();
        for (int i = 0; i < NCH; i++) begin
            mem_a[i] = 64'h4000_0000_0000_0000 + 64'(i);
            mem_b[i] = mem_a[i];
        end
        mem_a[0] = mem_a[0] + 64'd7;
        mem_a[3] = mem_a[3] + 64'd1;
        mem_b[1] = mem_b[1] + 64'd2;
        mem_b[5] = mem_b[5] + 64'h100;
    endtask

    initial begin
        int d0;
        for (int i = 0; i < NCH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_gt", 64'(gt_mask), 64'd0);
        check("rst_lt", 64'(lt_mask), 64'd0);
        check("rst_eq", 64'(eq_mask), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done_sig), 64'd0);
        check("rst_sta", 64'(bus.cmp_sta), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        basic_data();
        run_scan(1, 1'b0, "basic");
        check("basic_gt_const", 64'(gt_mask), 64'h09);
        check("basic_lt_const", 64'(lt_mask), 64'h22);
        check("basic_eq_const", 64'(eq_mask), 64'hD4);
        run_scan(4, 1'b0, "lat4");
        run_scan(9, 1'b0, "lat9");
        run_scan(1, 1'b1, "start_busy");

        // Abort a scan in DRAIN while results are still in flight.
        fill_random();
        lat = 9;
        @(negedge clk);
        d0    = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        exp_gt = '0;
        exp_lt = '0;
        exp_eq = '0;
        check("abort_gt", 64'(gt_mask), 64'd0);
        check("abort_lt", 64'(lt_mask), 64'd0);
        check("abort_eq", 64'(eq_mask), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_scan(2, 1'b0, "after_abort");

        for (int k = 0; k < 6; k++) begin
            fill_random();
            run_scan(int'($urandom_range(1, 9)), 1'($urandom_range(1)), $sformatf("rnd%0d", k));
        end

`ifdef CMP_SCAN_STICKY_EN
        @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        exp_gt = '0;
        exp_lt = '0;
        @(negedge clk);
        check("stk_clr_gt", 64'(gt_mask), 64'd0);
        for (int i = 0; i < NCH; i++) begin
            mem_a[i] = 64'(i);
            mem_b[i] = 64'(i);
        end
        mem_a[0] = 64'd50;
        run_scan(1, 1'b0, "stk1");
        mem_a[0] = 64'd0;
        mem_a[7] = 64'd90;
        run_scan(3, 1'b0, "stk2");
        check("stk_or_const", 64'(gt_mask), 64'h81);

        // sticky_clr lands on the publish edge of the next scan.
        lat = 1;
        model_scan();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        check("stkclr_done", 64'(done_sig), 64'd1);
        repeat (5) @(negedge clk);
        check("stkclr_gt", 64'(gt_mask), 64'd0);
        check("stkclr_lt", 64'(lt_mask), 64'd0);
        check("stkclr_eq", 64'(eq_mask), 64'(exp_eq));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_scan_seq.md
Name: cmp_scan_seq

Overview:
- Upstream sequencer for the 64-bit extended-single comparator stage.
- Scans NUM_CH operand pairs from a dual-read operand RAM and issues one compare per cycle (sta, input_1, input_2).
- Collects the comparator's greater/less flags on its done strobe and publishes per-channel gt/lt/eq masks atomically.
- Used in the real-time solver to evaluate switch and limit conditions each solution step.

Parameters:
- NUM_CH, 8, number of operand pairs scanned per start.
- ADDR_W, 3, operand RAM address width; must satisfy 2**ADDR_W >= NUM_CH.
- DATA_W, 64, operand width; equals EXTENDED_SINGLE.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-low reset
- start  in  1  single-cycle pulse; begins a scan when idle
- rd_addr  out  ADDR_W  operand RAM read address
- rd_data_a  in  DATA_W  operand A; valid 1 cycle after rd_addr
- rd_data_b  in  DATA_W  operand B; valid 1 cycle after rd_addr
- cmp_sta  out  1  compare-issue strobe to comparator sta
- cmp_a  out  DATA_W  to comparator input_1
- cmp_b  out  DATA_W  to comparator input_2
- cmp_gt  in  1  comparator output_1 (a>b)
- cmp_lt  in  1  comparator output_2 (a<b)
- cmp_done  in  1  comparator done_sig; qualifies cmp_gt/cmp_lt
- gt_mask  out  NUM_CH  bit i = pair i, a>b
- lt_mask  out  NUM_CH  bit i = pair i, a<b
- eq_mask  out  NUM_CH  bit i = ~gt & ~lt
- busy  out  1  high from accepted start until done_sig
- done_sig  out  1  one-cycle pulse when the masks update

Behaviour:
- Reset (rst==0 at clk edge):
  - All outputs 0; masks 0.
  - FSM to IDLE; issue and return counters 0.
  - Any scan in progress is abandoned; cmp_done pulses arriving after reset release are ignored until the next start.
- States IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 -> ISSUE, busy=1, issue_cnt=0, ret_cnt=0, shadow masks cleared.
  - start while not IDLE is ignored.
- ISSUE:
  - Each cycle: rd_addr=issue_cnt, issue_cnt++.
  - One cycle later, rd_data_a/b are registered onto cmp_a/cmp_b with cmp_sta=1. The issue pipeline is one register deep.
  - After address NUM_CH-1 is issued -> DRAIN.
  - Exactly NUM_CH cmp_sta pulses per scan, on consecutive cycles.
  - cmp_a/cmp_b hold their last value when cmp_sta=0.
- Return path (ISSUE or DRAIN):
  - On cmp_done=1, write shadow_gt[ret_cnt]=cmp_gt, shadow_lt[ret_cnt]=cmp_lt, shadow_eq[ret_cnt]=~cmp_gt&~cmp_lt; then ret_cnt++.
  - Comparator latency is not assumed; ordering is in-order by construction.
  - A cmp_done that arrives in the same cycle as an issue is handled.
- DRAIN:
  - cmp_done with ret_cnt==NUM_CH-1 -> DONE.
- DONE (one cycle):
  - Copy shadows to gt/lt/eq_mask; done_sig=1; busy=0.
  - -> IDLE.
  - start in this cycle is ignored.
- Masks are stable between done pulses.
- Minimum scan: NUM_CH + comparator latency + 3 cycles.
- NaN operands give gt=lt=0, so the eq bit is set. This is documented; it is not an error.
- cmp_done while IDLE is ignored.

Optional Feature:
- Macro CMP_SCAN_STICKY_EN.
- Defined:
  - Adds input port sticky_clr (1 bit).
  - At DONE, gt_mask and lt_mask become OR of the previous value and the new shadow. eq_mask is always overwritten.
  - sticky_clr=1 zeroes gt_mask/lt_mask next cycle; sticky_clr has priority over a simultaneous DONE OR-in, and the DONE result is lost.
- Undefined:
  - No sticky_clr port; all masks are overwritten each DONE.

Decomposition:
- Shared package/include (Global_parameter): EXTENDED_SINGLE width, FSM state encodings (CMP_SCAN_IDLE/ISSUE/DRAIN/DONE), default NUM_CH.
- One sub-module, cmp_scan_collect: ret_cnt, shadow registers, mask publish and sticky logic.
- The top level holds the FSM and the issue pipeline.

Test Plan:
- Reset then idle:
  - rst=0 for 3 cycles, start=0.
  - Expect masks=0, busy=0, done_sig=0, cmp_sta=0.
- Basic scan, NUM_CH=8, comparator latency 1:
  - RAM pairs: a>b at 0,3; a<b at 1,5; equal elsewhere.
  - Expect gt_mask=8'h09, lt_mask=8'h22, eq_mask=8'hD4.
  - Expect 8 consecutive cmp_sta pulses and done_sig 12 cycles after start.
- Latency sweep:
  - Comparator model latency 1, 4 and 9 with the same data.
  - Expect identical masks; done_sig moves by the latency delta.
- start while busy:
  - Pulse start at cycles 3 and at DONE.
  - Expect a single scan, exactly 8 cmp_sta pulses, one done_sig.
- Reset mid-scan:
  - Assert rst=0 during DRAIN with 3 results pending; late cmp_done pulses follow.
  - Expect masks=0, busy=0, no done_sig; the next scan is correct.
- Sticky (CMP_SCAN_STICKY_EN):
  - Scan 1 gives gt=8'h01; scan 2 data gives gt=8'h80. Expect gt_mask=8'h81.
  - Then sticky_clr coinciding with a DONE. Expect gt_mask=8'h00.
